// File: rtl/decode_stage_hs.sv
// Decode stage: field/immediate extraction, register file with writeback bypass,
// per-register counting scoreboard for RAW/structural stalls, valid/ready on both sides.
module decode_stage_hs #(
  parameter int ADDRESS_WIDTH     = 64,
  parameter int REGISTER_WIDTH    = 64,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int NUM_REGS          = 32,
  parameter int REGISTERNO_WIDTH  = $clog2(NUM_REGS),
  parameter int SB_COUNT_WIDTH    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         out_in_ready,
  input  logic [ADDRESS_WIDTH-1:0]     in_pcplus1,
  input  logic [INSTRUCTION_WIDTH-1:0] in_instruction_bits,
  input  logic                         in_wb_enable,
  input  logic [REGISTERNO_WIDTH-1:0]  in_wb_rd_regno,
  input  logic [REGISTER_WIDTH-1:0]    in_wb_rd_value,
  input  logic                         in_branch_taken_bool,
  input  logic                         in_syscall_flush,
  input  logic                         in_out_ready,
  output logic                         out_valid,
  output logic [ADDRESS_WIDTH-1:0]     out_pcplus1,
  output logic [REGISTER_WIDTH-1:0]    out_rs1_value,
  output logic [REGISTER_WIDTH-1:0]    out_rs2_value,
  output logic [REGISTER_WIDTH-1:0]    out_imm_value,
  output logic [REGISTERNO_WIDTH-1:0]  out_rs1_regno,
  output logic [REGISTERNO_WIDTH-1:0]  out_rs2_regno,
  output logic [REGISTERNO_WIDTH-1:0]  out_rd_regno,
  output logic [6:0]                   out_opcode,
  output logic [2:0]                   out_funct3,
  output logic [6:0]                   out_funct7,
  output logic                         out_rd_we,
  output logic                         out_illegal
);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0]    pc;
    logic [REGISTER_WIDTH-1:0]   rs1_val;
    logic [REGISTER_WIDTH-1:0]   rs2_val;
    logic [REGISTER_WIDTH-1:0]   imm;
    logic [REGISTERNO_WIDTH-1:0] rs1;
    logic [REGISTERNO_WIDTH-1:0] rs2;
    logic [REGISTERNO_WIDTH-1:0] rd;
    logic [6:0]                  opcode;
    logic [2:0]                  funct3;
    logic [6:0]                  funct7;
    logic                        rd_we;
    logic                        illegal;
  } dec_t;

  logic [NUM_REGS-1:0][REGISTER_WIDTH-1:0] rf;
  logic [NUM_REGS-1:0][SB_COUNT_WIDTH-1:0] sb_cnt, sb_nxt;
  logic [INSTRUCTION_WIDTH-1:0]            ib;
  dec_t                                    dec, out_q;
  logic                                    out_v;
  logic use_rs1, use_rs2, writes, busy1, busy2, rd_full;
  logic wb_hit, flush, sq_dec, in_rdy, accept;
  logic inc_r, wb_r, sq_r;

  assign ib     = in_instruction_bits;
  assign wb_hit = in_wb_enable && (in_wb_rd_regno != '0);
  assign flush  = in_branch_taken_bool || in_syscall_flush;

  always_comb begin
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    writes      = 1'b0;
    dec         = '0;
    dec.pc      = in_pcplus1;
    dec.opcode  = ib[6:0];
    dec.rd      = ib[11:7];
    dec.funct3  = ib[14:12];
    dec.rs1     = ib[19:15];
    dec.rs2     = ib[24:20];
    dec.funct7  = ib[31:25];
    case (ib[6:0])
      7'b0110011, 7'b0111011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; writes = 1'b1; end
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: begin
        use_rs1 = 1'b1; writes = 1'b1;
        dec.imm = {{(REGISTER_WIDTH-12){ib[31]}}, ib[31:20]};
      end
      7'b0100011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.imm = {{(REGISTER_WIDTH-12){ib[31]}}, ib[31:25], ib[11:7]};
      end
      7'b1100011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.imm = {{(REGISTER_WIDTH-13){ib[31]}}, ib[31], ib[7], ib[30:25], ib[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        writes  = 1'b1;
        dec.imm = {{(REGISTER_WIDTH-32){ib[31]}}, ib[31:12], 12'b0};
      end
      7'b1101111: begin
        writes  = 1'b1;
        dec.imm = {{(REGISTER_WIDTH-21){ib[31]}}, ib[31], ib[19:12], ib[20], ib[30:21], 1'b0};
      end
      7'b1110011: ;
      default: dec.illegal = 1'b1;
    endcase
    dec.rd_we = writes && (dec.rd != '0);
    // Same-cycle writeback is forwarded so the stall can release on the wb cycle.
    if (use_rs1 && dec.rs1 != '0)
      dec.rs1_val = (wb_hit && in_wb_rd_regno == dec.rs1) ? in_wb_rd_value : rf[dec.rs1];
    if (use_rs2 && dec.rs2 != '0)
      dec.rs2_val = (wb_hit && in_wb_rd_regno == dec.rs2) ? in_wb_rd_value : rf[dec.rs2];
  end

  always_comb begin
    busy1 = use_rs1 && dec.rs1 != '0 && sb_cnt[dec.rs1] != '0 &&
            !(wb_hit && in_wb_rd_regno == dec.rs1 && sb_cnt[dec.rs1] == SB_COUNT_WIDTH'(1));
    busy2 = use_rs2 && dec.rs2 != '0 && sb_cnt[dec.rs2] != '0 &&
            !(wb_hit && in_wb_rd_regno == dec.rs2 && sb_cnt[dec.rs2] == SB_COUNT_WIDTH'(1));
    rd_full = dec.rd_we && (&sb_cnt[dec.rd]);
    in_rdy  = (!out_v || in_out_ready) && !(busy1 || busy2 || rd_full) && !flush;
    accept  = in_valid && in_rdy;
    sq_dec  = in_branch_taken_bool && !in_syscall_flush && out_v && out_q.rd_we;
  end

  // Increment and wb decrement on one counter cancel; otherwise decrements floor at 0.
  always_comb begin
    sb_nxt = sb_cnt;
    inc_r  = 1'b0;
    wb_r   = 1'b0;
    sq_r   = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc_r = accept && dec.rd_we && dec.rd == REGISTERNO_WIDTH'(r);
      wb_r  = wb_hit && in_wb_rd_regno == REGISTERNO_WIDTH'(r);
      sq_r  = sq_dec && out_q.rd == REGISTERNO_WIDTH'(r);
      if (inc_r) begin
        if (!wb_r) sb_nxt[r] = sb_cnt[r] + SB_COUNT_WIDTH'(1);
      end else if (wb_r && sq_r) begin
        sb_nxt[r] = (sb_cnt[r] > SB_COUNT_WIDTH'(1)) ? sb_cnt[r] - SB_COUNT_WIDTH'(2) : '0;
      end else if (wb_r || sq_r) begin
        sb_nxt[r] = (sb_cnt[r] != '0) ? sb_cnt[r] - SB_COUNT_WIDTH'(1) : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_v  <= 1'b0;
      out_q  <= '0;
      sb_cnt <= '0;
      rf     <= '0;
    end else begin
      if (wb_hit) rf[in_wb_rd_regno] <= in_wb_rd_value;
      sb_cnt <= in_syscall_flush ? '0 : sb_nxt;
      if (accept) begin
        out_q <= dec;
        out_v <= 1'b1;
      end else if (flush || in_out_ready) begin
        out_v <= 1'b0;
      end
    end
  end

  assign out_in_ready  = in_rdy;
  assign out_valid     = out_v;
  assign out_pcplus1   = out_q.pc;
  assign out_rs1_value = out_q.rs1_val;
  assign out_rs2_value = out_q.rs2_val;
  assign out_imm_value = out_q.imm;
  assign out_rs1_regno = out_q.rs1;
  assign out_rs2_regno = out_q.rs2;
  assign out_rd_regno  = out_q.rd;
  assign out_opcode    = out_q.opcode;
  assign out_funct3    = out_q.funct3;
  assign out_funct7    = out_q.funct7;
  assign out_rd_we     = out_q.rd_we;
  assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Scoreboarded bench for decode_stage_hs: directed scenarios then random traffic,
// checked against an arithmetic reference model of the decode rules.
module tb_decode_stage_hs;

  logic        clk, reset, in_valid, out_in_ready;
  logic [63:0] in_pcplus1;
  logic [31:0] in_instruction_bits;
  logic        in_wb_enable;
  logic [4:0]  in_wb_rd_regno;
  logic [63:0] in_wb_rd_value;
  logic        in_branch_taken_bool, in_syscall_flush, in_out_ready;
  logic        out_valid;
  logic [63:0] out_pcplus1, out_rs1_value, out_rs2_value, out_imm_value;
  logic [4:0]  out_rs1_regno, out_rs2_regno, out_rd_regno;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3;
  logic        out_rd_we, out_illegal;

  decode_stage_hs dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .out_in_ready(out_in_ready),
    .in_pcplus1(in_pcplus1), .in_instruction_bits(in_instruction_bits),
    .in_wb_enable(in_wb_enable), .in_wb_rd_regno(in_wb_rd_regno), .in_wb_rd_value(in_wb_rd_value),
    .in_branch_taken_bool(in_branch_taken_bool), .in_syscall_flush(in_syscall_flush),
    .in_out_ready(in_out_ready), .out_valid(out_valid), .out_pcplus1(out_pcplus1),
    .out_rs1_value(out_rs1_value), .out_rs2_value(out_rs2_value), .out_imm_value(out_imm_value),
    .out_rs1_regno(out_rs1_regno), .out_rs2_regno(out_rs2_regno), .out_rd_regno(out_rd_regno),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rd_we(out_rd_we), .out_illegal(out_illegal)
  );

  typedef struct {
    bit [63:0] pc, v1, v2, imm;
    bit [4:0]  rs1, rs2, rd;
    bit [6:0]  op, f7;
    bit [2:0]  f3;
    bit        we, ill, u1, u2;
  } exp_t;

  exp_t      sb_q[$];
  int        checks, errors;
  bit [63:0] regs[32];
  int        cnt[32];
  bit        mvalid;
  exp_t      cur;

  initial begin clk = 0; forever #5 clk = ~clk; end

  function automatic void chk(string n, logic [63:0] act, logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", n, act, exp_v, $time);
    end
  endfunction

  // fmt: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
  function automatic void classify(input bit [6:0] op, output bit u1, output bit u2,
                                   output bit wr, output bit ill, output int fmt);
    u1 = 0; u2 = 0; wr = 0; ill = 0; fmt = 0;
    case (op)
      7'b0110011, 7'b0111011: begin u1 = 1; u2 = 1; wr = 1; end
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: begin u1 = 1; wr = 1; fmt = 1; end
      7'b0100011: begin u1 = 1; u2 = 1; fmt = 2; end
      7'b1100011: begin u1 = 1; u2 = 1; fmt = 3; end
      7'b0110111, 7'b0010111: begin wr = 1; fmt = 4; end
      7'b1101111: begin wr = 1; fmt = 5; end
      7'b1110011: ;
      default: ill = 1;
    endcase
  endfunction

  // Two's-complement value built from weighted bit groups, sign bit weighted negatively.
  function automatic bit [63:0] ref_imm(input bit [31:0] i, input int fmt);
    longint v;
    longint s;
    s = longint'(i[31]);
    case (fmt)
      1: v = longint'(i[30:20]) - s * 2048;
      2: v = longint'(i[30:25]) * 32 + longint'(i[11:7]) - s * 2048;
      3: v = longint'(i[11:8]) * 2 + longint'(i[30:25]) * 32 + longint'(i[7]) * 2048 - s * 4096;
      4: v = longint'(i[30:12]) * 4096 - s * (longint'(1) << 31);
      5: v = longint'(i[30:21]) * 2 + longint'(i[20]) * 2048 + longint'(i[19:12]) * 4096
             - s * (longint'(1) << 20);
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  function automatic bit [63:0] rd_val(input bit [4:0] rs, input bit we, input bit [4:0] wrd,
                                       input bit [63:0] wv);
    if (rs == 0) return 0;
    if (we && wrd == rs) return wv;
    return regs[rs];
  endfunction

  function automatic bit busy(input bit [4:0] rs, input bit we, input bit [4:0] wrd);
    if (rs == 0 || cnt[rs] == 0) return 0;
    return !(we && wrd == rs && cnt[rs] == 1);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin regs[r] = 0; cnt[r] = 0; end
    mvalid = 0;
    sb_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; in_valid = 0; in_wb_enable = 0; in_branch_taken_bool = 0;
    in_syscall_flush = 0; in_out_ready = 1;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  // One cycle: drive at negedge, predict ready/accept, push expectation, advance model.
  task automatic cyc(input bit v, input bit [31:0] ins, input bit we, input bit [4:0] wrd,
                     input bit [63:0] wv, input bit br, input bit sy, input bit rdy);
    bit u1, u2, wr, ill, stall, exp_rdy, acc;
    int fmt;
    exp_t e;
    int dec[32];
    @(negedge clk);
    e.pc = {$urandom, $urandom};
    in_valid = v; in_instruction_bits = ins; in_pcplus1 = e.pc;
    in_wb_enable = we; in_wb_rd_regno = wrd; in_wb_rd_value = wv;
    in_branch_taken_bool = br; in_syscall_flush = sy; in_out_ready = rdy;
    #2;
    classify(ins[6:0], u1, u2, wr, ill, fmt);
    e.op = ins[6:0]; e.rd = ins[11:7]; e.f3 = ins[14:12];
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.f7 = ins[31:25];
    e.u1 = u1; e.u2 = u2; e.ill = ill; e.we = wr && e.rd != 0;
    e.imm = ref_imm(ins, fmt);
    e.v1 = rd_val(e.rs1, we, wrd, wv);
    e.v2 = rd_val(e.rs2, we, wrd, wv);
    stall = (u1 && busy(e.rs1, we, wrd)) || (u2 && busy(e.rs2, we, wrd)) ||
            (e.we && cnt[e.rd] == 3);
    exp_rdy = (!mvalid || rdy) && !stall && !br && !sy;
    chk("in_ready", out_in_ready, exp_rdy);
    acc = v && exp_rdy;
    if (acc) sb_q.push_back(e);
    for (int r = 0; r < 32; r++) dec[r] = 0;
    if (sy) begin
      for (int r = 0; r < 32; r++) cnt[r] = 0;
    end else begin
      if (we && wrd != 0) dec[wrd]++;
      if (br && mvalid && cur.we) dec[cur.rd]++;
      if (acc && e.we) begin
        if (dec[e.rd] > 0) dec[e.rd]--; else cnt[e.rd]++;
      end
      for (int r = 0; r < 32; r++) cnt[r] = (cnt[r] > dec[r]) ? cnt[r] - dec[r] : 0;
    end
    if (we && wrd != 0) regs[wrd] = wv;
    if (br || sy) mvalid = 0;
    else if (acc) begin mvalid = 1; cur = e; end
    else if (rdy) mvalid = 0;
  endtask

  task automatic idle(input bit rdy);
    cyc(0, 32'h0000_0013, 0, 0, 0, 0, 0, rdy);
  endtask

  // Monitor: compare the presented output against the scoreboard head each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (!reset) begin
        chk("out_valid", out_valid, sb_q.size() != 0);
        if (sb_q.size() != 0) begin
          e = sb_q[0];
          if (out_valid) begin
            chk("pc", out_pcplus1, e.pc);
            chk("opcode", out_opcode, e.op);
            chk("funct3", out_funct3, e.f3);
            chk("funct7", out_funct7, e.f7);
            chk("rs1_regno", out_rs1_regno, e.rs1);
            chk("rs2_regno", out_rs2_regno, e.rs2);
            chk("rd_regno", out_rd_regno, e.rd);
            chk("imm", out_imm_value, e.imm);
            chk("rd_we", out_rd_we, e.we);
            chk("illegal", out_illegal, e.ill);
            if (e.u1) chk("rs1_value", out_rs1_value, e.v1);
            if (e.u2) chk("rs2_value", out_rs2_value, e.v2);
          end
          if (!out_valid || in_out_ready || in_branch_taken_bool || in_syscall_flush)
            void'(sb_q.pop_front());
        end
      end
    end
  end

  function automatic bit [31:0] rnd_ins();
    bit [6:0]  ops[14];
    bit [31:0] i;
    ops = '{7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111,
            7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011,
            7'b0001111, 7'b1111111};
    i = $urandom;
    i[6:0]   = ops[$urandom_range(0, 13)];
    i[11:7]  = 5'($urandom_range(0, 7));
    i[19:15] = 5'($urandom_range(0, 7));
    i[24:20] = 5'($urandom_range(0, 7));
    return i;
  endfunction

  initial begin
    checks = 0; errors = 0;
    reset = 1; in_valid = 0; in_pcplus1 = 0; in_instruction_bits = 0;
    in_wb_enable = 0; in_wb_rd_regno = 0; in_wb_rd_value = 0;
    in_branch_taken_bool = 0; in_syscall_flush = 0; in_out_ready = 1;
    do_reset();
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_imm", out_imm_value, 0);
    chk("rst_rd", out_rd_regno, 0);
    chk("rst_rs1v", out_rs1_value, 0);

    // addi x1,x0,5 then add x2,x1,x1 stalls until wb x1
    cyc(1, 32'h0050_0093, 0, 0, 0, 0, 0, 1);
    cyc(1, 32'h0010_8133, 0, 0, 0, 0, 0, 1);
    chk("addi_valid", out_valid, 1);
    chk("addi_rd", out_rd_regno, 1);
    chk("addi_imm", out_imm_value, 5);
    chk("addi_we", out_rd_we, 1);
    chk("raw_stall", out_in_ready, 0);
    cyc(1, 32'h0010_8133, 1, 1, 64'd5, 0, 0, 1);
    chk("wb_release", out_in_ready, 1);
    cyc(1, 32'hFE00_0EE3, 0, 0, 0, 0, 0, 1);
    chk("bypass_rs1", out_rs1_value, 5);
    chk("bypass_rs2", out_rs2_value, 5);
    cyc(1, 32'h8000_01B7, 0, 0, 0, 0, 0, 1);
    chk("beq_imm", out_imm_value, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_we", out_rd_we, 0);
    // back-pressure hold
    for (int k = 0; k < 3; k++) begin
      cyc(1, 32'h0010_0213, 0, 0, 0, 0, 0, 0);
      chk("lui_imm_hold", out_imm_value, 64'hFFFF_FFFF_8000_0000);
      chk("hold_ready", out_in_ready, 0);
    end
    cyc(1, 32'h0010_0213, 0, 0, 0, 0, 0, 1);
    idle(1);
    chk("release_rd", out_rd_regno, 4);

    // scoreboard saturation on x5
    for (int k = 1; k <= 3; k++) cyc(1, 32'h0000_0293 | (k << 20), 0, 0, 0, 0, 0, 1);
    cyc(1, 32'h0040_0293, 0, 0, 0, 0, 0, 1);
    chk("sat_stall", out_in_ready, 0);
    cyc(1, 32'h0040_0293, 1, 5, 64'h55, 0, 0, 1);
    chk("sat_stall_wb", out_in_ready, 0);
    cyc(1, 32'h0040_0293, 0, 0, 0, 0, 0, 1);
    chk("sat_release", out_in_ready, 1);

    // branch flush squashes a writer to x7
    idle(1);
    cyc(1, 32'h0000_0393, 0, 0, 0, 0, 0, 0);
    cyc(0, 32'h0000_0013, 0, 0, 0, 1, 0, 0);
    chk("br_ready", out_in_ready, 0);
    cyc(1, 32'h0073_8433, 0, 0, 0, 0, 0, 1);
    chk("br_valid", out_valid, 0);
    chk("br_cnt_restored", out_in_ready, 1);

    // syscall flush clears pending x9
    cyc(1, 32'h0000_0493, 0, 0, 0, 0, 0, 1);
    cyc(1, 32'h0094_8533, 0, 0, 0, 0, 0, 1);
    chk("sys_pre_stall", out_in_ready, 0);
    cyc(1, 32'h0094_8533, 0, 0, 0, 0, 1, 1);
    cyc(1, 32'h0094_8533, 0, 0, 0, 0, 0, 1);
    chk("sys_cleared", out_in_ready, 1);

    // reset during a hold discards the entry
    cyc(1, 32'h0000_0593, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h0000_0593, 0, 0, 0, 0, 0, 0);
    do_reset();
    #1;
    chk("rst_midstall", out_valid, 0);

    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) do_reset();
      else cyc(($urandom % 10) < 8, rnd_ins(), ($urandom % 10) < 4,
               5'($urandom_range(0, 7)), {$urandom, $urandom},
               ($urandom % 32) == 0, ($urandom % 64) == 0, ($urandom % 10) < 7);
    end
    idle(1);
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
